// File: rtl/encoder_pkg.sv
// encoder_pkg
// Shared constants and types for the sequential 8-to-3 encoder.
//   IN_W         : request vector width (fixed at 8)
//   CODE_W       : code width, clog2(IN_W)
//   scan_state_t : controller state {IDLE, SCAN}
package encoder_pkg;

  localparam int IN_W   = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/priority_enc_lsb.sv
// priority_enc_lsb
// Combinational LSB-first priority encoder over the pending mask.
// Ports:
//   pend   in  [IN_W-1:0]   pending request bits
//   idx    out [CODE_W-1:0] index of the lowest set bit (0 when pend == 0)
//   onehot out [IN_W-1:0]   isolated lowest set bit
//   any    out              pend is nonzero
//   single out              pend has exactly one bit set
module priority_enc_lsb
  import encoder_pkg::*;
(
  input  logic [IN_W-1:0]   pend,
  output logic [CODE_W-1:0] idx,
  output logic [IN_W-1:0]   onehot,
  output logic              any,
  output logic              single
);

  // Isolate the lowest set bit (two's complement trick) and flag set-bit counts.
  always_comb begin
    onehot = pend & (~pend + IN_W'(1));
    any    = |pend;
    // Clearing the lowest bit leaves zero only when at most one bit was set.
    single = any & ~(|(pend & (pend - IN_W'(1))));
  end

  // Turn the isolated one-hot bit into its binary index.
  always_comb begin
    idx = {CODE_W{1'b0}};
    for (int i = 0; i < IN_W; i++) begin
      if (onehot[i]) begin
        idx = idx | CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/encoder_scan.sv
// encoder_scan
// Serialises a multi-hot request vector into one binary index per beat,
// lowest index first, marking the final beat with last.
// Ports:
//   clk        in               rising-edge clock
//   rst        in               synchronous active-high reset
//   en         in               block enable; low flushes any scan
//   in         in  [IN_W-1:0]   request vector
//   in_valid   in               in is valid
//   in_ready   out              block can accept a vector
//   out        out [CODE_W-1:0] index of the current set bit
//   out_valid  out              out and last are valid
//   out_ready  in               downstream accepts the beat
//   last       out              current beat is the final set bit
module encoder_scan
  import encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_W-1:0]   in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              last
);

  scan_state_t       state_r;
  scan_state_t       state_nxt_s;
  logic [IN_W-1:0]   pend_r;
  logic [IN_W-1:0]   pend_nxt_s;

  logic [CODE_W-1:0] idx_s;
  logic [IN_W-1:0]   onehot_s;
  logic              any_s;
  logic              single_s;

  priority_enc_lsb u_enc (
    .pend   (pend_r),
    .idx    (idx_s),
    .onehot (onehot_s),
    .any    (any_s),
    .single (single_s)
  );

  // Next-state, pending-mask update and handshake outputs.
  // rst and en=0 both force all outputs low and return to an empty IDLE.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out         = {CODE_W{1'b0}};
    last        = 1'b0;

    if (rst || !en) begin
      state_nxt_s = IDLE;
      pend_nxt_s  = {IN_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            // An all-zero vector is consumed without producing any beat.
            if (in != {IN_W{1'b0}}) begin
              pend_nxt_s  = in;
              state_nxt_s = SCAN;
            end else begin
              pend_nxt_s  = {IN_W{1'b0}};
              state_nxt_s = IDLE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SCAN: begin
          // pend is never empty in SCAN; any only guards a corrupted state.
          out_valid = any_s;
          out       = any_s ? idx_s : {CODE_W{1'b0}};
          last      = any_s & single_s;
          if (out_ready || !any_s) begin
            pend_nxt_s = pend_r & ~onehot_s;
            if (single_s || !any_s) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = SCAN;
            end
          end else begin
            state_nxt_s = SCAN;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          pend_nxt_s  = {IN_W{1'b0}};
        end
      endcase
    end
  end

  // State and pending-mask registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      pend_r  <= {IN_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

endmodule

// File: tb/tb_encoder_scan.sv
// tb_encoder_scan
// Directed self-checking bench for encoder_scan. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_encoder_scan;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       last;

  int errors;
  int checks;
  logic [7:0] last_out_seen;
  logic       last_acc_seen;

  encoder_scan dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample all outputs on the falling edge, then advance to 1 unit past the
  // next rising edge so the caller can drive the following cycle.
  task automatic expect_cycle(input string tag, input logic e_ir, input logic e_ov,
                              input logic [2:0] e_out, input logic e_last);
    @(negedge clk);
    chk({tag, ".in_ready"},  {7'd0, in_ready},  {7'd0, e_ir});
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e_ov});
    chk({tag, ".out"},       {5'd0, out},       {5'd0, e_out});
    chk({tag, ".last"},      {7'd0, last},      {7'd0, e_last});
    last_out_seen = {5'd0, out};
    last_acc_seen = out_valid & out_ready;
    @(posedge clk);
    #1;
  endtask

  // Offer a vector in IDLE for one cycle; it is accepted at the next edge.
  task automatic accept(input string tag, input logic [7:0] vec);
    in       = vec;
    in_valid = 1'b1;
    expect_cycle(tag, 1'b1, 1'b0, 3'd0, 1'b0);
    in_valid = 1'b0;
    in       = 8'hA5;
  endtask

  initial begin
    logic [7:0] dec_or;
    int         code;
    int         n;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    en        = 1'b1;
    in        = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    // Reset dominates a valid offer.
    expect_cycle("reset_a", 1'b0, 1'b0, 3'd0, 1'b0);
    expect_cycle("reset_b", 1'b0, 1'b0, 3'd0, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    expect_cycle("post_rst_a", 1'b1, 1'b0, 3'd0, 1'b0);
    expect_cycle("post_rst_b", 1'b1, 1'b0, 3'd0, 1'b0);

    // Full vector 1010_0110 -> 1,2,5,7.
    accept("full_acc", 8'b1010_0110);
    expect_cycle("full_b1", 1'b0, 1'b1, 3'd1, 1'b0);
    expect_cycle("full_b2", 1'b0, 1'b1, 3'd2, 1'b0);
    expect_cycle("full_b5", 1'b0, 1'b1, 3'd5, 1'b0);
    expect_cycle("full_b7", 1'b0, 1'b1, 3'd7, 1'b1);
    expect_cycle("full_idle", 1'b1, 1'b0, 3'd0, 1'b0);

    // Backpressure on 8'hFF with a junk vector offered while busy.
    accept("bp_acc", 8'hFF);
    in     = 8'h5A;
    dec_or = 8'h00;
    code   = 0;
    n      = 0;
    while (code < 8 && n < 40) begin
      out_ready = (n % 3 == 0);
      in_valid  = (code != 7);
      expect_cycle($sformatf("bp_c%0d_n%0d", code, n), 1'b0, 1'b1, 3'(code), code == 7);
      if (last_acc_seen) begin
        dec_or = dec_or | (8'd1 << last_out_seen[2:0]);
        code++;
      end else begin
        code = code;
      end
      n++;
    end
    chk("bp_bound", {7'd0, code == 8}, 8'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_cycle("bp_idle", 1'b1, 1'b0, 3'd0, 1'b0);
    chk("bp_decode_or", dec_or, 8'hFF);

    // Zero vector is swallowed; single-bit boundaries.
    accept("zero_acc", 8'h00);
    expect_cycle("zero_idle", 1'b1, 1'b0, 3'd0, 1'b0);
    accept("lsb_acc", 8'h01);
    expect_cycle("lsb_b0", 1'b0, 1'b1, 3'd0, 1'b1);
    expect_cycle("lsb_idle", 1'b1, 1'b0, 3'd0, 1'b0);
    accept("msb_acc", 8'h80);
    expect_cycle("msb_b7", 1'b0, 1'b1, 3'd7, 1'b1);
    expect_cycle("msb_idle", 1'b1, 1'b0, 3'd0, 1'b0);

    // Flush after the first beat of 8'hF0, then 8'h03 shows no residue.
    accept("fl_acc", 8'hF0);
    expect_cycle("fl_b4", 1'b0, 1'b1, 3'd4, 1'b0);
    en = 1'b0;
    expect_cycle("fl_off", 1'b0, 1'b0, 3'd0, 1'b0);
    en = 1'b1;
    expect_cycle("fl_idle", 1'b1, 1'b0, 3'd0, 1'b0);
    accept("fl2_acc", 8'h03);
    expect_cycle("fl2_b0", 1'b0, 1'b1, 3'd0, 1'b0);
    expect_cycle("fl2_b1", 1'b0, 1'b1, 3'd1, 1'b1);
    expect_cycle("fl2_idle", 1'b1, 1'b0, 3'd0, 1'b0);

    // Reset during beat 3 of 8'h3C aborts the scan.
    accept("rm_acc", 8'h3C);
    expect_cycle("rm_b2", 1'b0, 1'b1, 3'd2, 1'b0);
    rst = 1'b1;
    expect_cycle("rm_rst", 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    expect_cycle("rm_idle_a", 1'b1, 1'b0, 3'd0, 1'b0);
    expect_cycle("rm_idle_b", 1'b1, 1'b0, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
